// File: rtl/ber_meter.sv
// Bit-error-rate meter: compares rx_sig against a DELAY-beat delayed ref_sig over WINDOW valid beats.
// Optional macro BER_AUTO_RESTART_EN makes windows run back-to-back until reset.
module ber_meter #(
  parameter  int WINDOW = 256,
  parameter  int DELAY  = 8,
  localparam int CNT_W  = $clog2(WINDOW + 1)
) (
  input  logic             clk_sig,
  input  logic             reset_sig,
  input  logic             start_sig,
  input  logic             valid_sig,
  input  logic             ref_sig,
  input  logic             rx_sig,
  output logic [CNT_W-1:0] err_cnt_sig,
  output logic             done_sig,
  output logic             busy_sig,
  output logic             err_sig
);

  localparam int SYNC_W = (DELAY < 1) ? 1 : $clog2(DELAY + 1);
  localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'((DELAY > 0) ? DELAY - 1 : 0);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(WINDOW);

`ifdef BER_AUTO_RESTART_EN
  localparam bit AUTO_RESTART = 1'b1;
`else
  localparam bit AUTO_RESTART = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SYNC    = 2'd1,
    S_MEASURE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [SYNC_W-1:0] r_sync_cnt;
  logic [CNT_W-1:0]  r_bit_cnt;
  logic [CNT_W-1:0]  r_err_cnt;
  logic [CNT_W-1:0]  r_err_out;
  logic              r_done;
  logic              r_busy;
  logic              r_err;
  logic              w_ref_dly;
  logic              w_mis;
  logic              w_cmp_en;
  logic              w_last;
  logic [CNT_W-1:0]  w_bit_base;
  logic [CNT_W-1:0]  w_err_base;
  logic [CNT_W-1:0]  w_bit_inc;
  logic [CNT_W-1:0]  w_err_inc;

  // Reference delay line shifts on every valid beat regardless of state.
  generate
    if (DELAY == 0) begin : g_nodly
      assign w_ref_dly = ref_sig;
    end else begin : g_dly
      logic [DELAY-1:0] r_dly;
      always_ff @(posedge clk_sig or posedge reset_sig) begin
        if (reset_sig) begin
          r_dly <= '0;
        end else if (valid_sig) begin
          r_dly <= (r_dly << 1) | DELAY'(ref_sig);
        end
      end
      assign w_ref_dly = r_dly[DELAY-1];
    end
  endgenerate

  // In auto-restart mode the DONE beat is the first beat of the next window.
  always_comb begin
    w_next     = r_state;
    w_mis      = rx_sig ^ w_ref_dly;
    w_cmp_en   = valid_sig && ((r_state == S_MEASURE) ||
                               (AUTO_RESTART && (r_state == S_DONE)));
    w_bit_base = (r_state == S_MEASURE) ? r_bit_cnt : '0;
    w_err_base = (r_state == S_MEASURE) ? r_err_cnt : '0;
    w_bit_inc  = w_bit_base + CNT_W'(1);
    w_err_inc  = w_err_base + CNT_W'(w_mis);
    w_last     = w_cmp_en && (w_bit_inc == CNT_LAST);
    case (r_state)
      S_IDLE: begin
        if (start_sig) w_next = (DELAY == 0) ? S_MEASURE : S_SYNC;
      end
      S_SYNC: begin
        if (valid_sig && (r_sync_cnt == SYNC_LAST)) w_next = S_MEASURE;
      end
      S_MEASURE: begin
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        if (AUTO_RESTART) w_next = w_last ? S_DONE : S_MEASURE;
        else              w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sig or posedge reset_sig) begin
    if (reset_sig) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_busy  <= (w_next == S_SYNC) || (w_next == S_MEASURE);
      r_done  <= (w_next == S_DONE);
      r_err   <= w_cmp_en && w_mis;
    end
  end

  // Holding the counters clear throughout IDLE covers the clear-on-entry requirement.
  always_ff @(posedge clk_sig or posedge reset_sig) begin
    if (reset_sig) begin
      r_sync_cnt <= '0;
      r_bit_cnt  <= '0;
      r_err_cnt  <= '0;
      r_err_out  <= '0;
    end else begin
      if (r_state != S_SYNC) begin
        r_sync_cnt <= '0;
      end else if (valid_sig) begin
        r_sync_cnt <= r_sync_cnt + SYNC_W'(1);
      end
      if (w_cmp_en) begin
        r_bit_cnt <= w_bit_inc;
        r_err_cnt <= w_err_inc;
      end else if ((r_state == S_IDLE) || (r_state == S_DONE)) begin
        r_bit_cnt <= '0;
        r_err_cnt <= '0;
      end
      if (w_last) r_err_out <= w_err_inc;
    end
  end

  assign err_cnt_sig = r_err_out;
  assign done_sig    = r_done;
  assign busy_sig    = r_busy;
  assign err_sig     = r_err;

endmodule

// File: tb/tb_ber_meter.sv
// Directed bench for ber_meter with WINDOW=16, DELAY=3; rx is built from a history of driven ref bits.
// Define BER_AUTO_RESTART_EN for both files to exercise back-to-back windows.
module tb_ber_meter;
  localparam int WINDOW = 16;
  localparam int DELAY  = 3;
  localparam int CNT_W  = $clog2(WINDOW + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             valid;
  logic             ref_b;
  logic             rx_b;
  logic [CNT_W-1:0] err_cnt;
  logic             done;
  logic             busy;
  logic             err;

  int   n_vec  = 0;
  int   n_fail = 0;
  logic hist [0:511];
  int   bn;
  int   w;
  int   lat, busy_cyc, err_pulses, done_pulses, cnt_at_done, idle_busy;
  logic post_busy, post_done;
  int   nd;
  int   d_at  [0:2];
  int   d_cnt [0:2];

  always #5 clk = ~clk;

  ber_meter #(.WINDOW(WINDOW), .DELAY(DELAY)) dut (
    .clk_sig     (clk),
    .reset_sig   (rst),
    .start_sig   (start),
    .valid_sig   (valid),
    .ref_sig     (ref_b),
    .rx_sig      (rx_b),
    .err_cnt_sig (err_cnt),
    .done_sig    (done),
    .busy_sig    (busy),
    .err_sig     (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  // rx carries the ref bit from DELAY beats earlier, optionally inverted.
  task automatic drive_beat(input logic v, input logic inv);
    valid = v;
    if (v) begin
      ref_b = 1'($urandom_range(0, 1));
      rx_b  = ((bn >= DELAY) ? hist[bn-DELAY] : 1'b0) ^ inv;
      if (bn < 512) hist[bn] = ref_b;
      bn++;
    end
  endtask

  // mode: 0 clean, 1 invert window beats ia/ib, 2 invert every window beat.
  task automatic run_window(input int mode, input int ia, input int ib,
                            input bit gaps, input int extra_at);
    logic v;
    int   wb;
    bn = 0; busy_cyc = 0; err_pulses = 0; done_pulses = 0; lat = -1; cnt_at_done = -1;
    start = 1'b1;
    drive_beat(1'b1, 1'b0);
    for (int c = 1; (c <= 200) && (lat < 0); c++) begin
      @(posedge clk); #1;
      start = (c == extra_at);
      if (busy) busy_cyc++;
      if (err)  err_pulses++;
      if (done) begin
        done_pulses++;
        lat         = c;
        cnt_at_done = int'(err_cnt);
      end
      v  = gaps ? ((c % 2) == 0) : 1'b1;
      wb = bn - DELAY;
      drive_beat(v, v && (wb >= 1) && ((mode == 2) || (wb == ia) || (wb == ib)));
    end
    start = 1'b0;
    @(posedge clk); #1;
    post_busy = busy;
    post_done = done;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; valid = 1'b0; ref_b = 1'b0; rx_b = 1'b0; bn = 0;
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_cnt", err_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

`ifndef BER_AUTO_RESTART_EN
    run_window(0, -1, -1, 1'b0, 0);
    check("b1_latency", lat, 20);
    check("b1_busy_cycles", busy_cyc, 19);
    check("b1_done_pulses", done_pulses, 1);
    check("b1_err_cnt", cnt_at_done, 0);
    check("b1_err_pulses", err_pulses, 0);
    check("b1_done_after", post_done, 0);
    check("b1_busy_after", post_busy, 0);

    run_window(1, 5, 9, 1'b0, 0);
    check("b2_latency", lat, 20);
    check("b2_err_pulses", err_pulses, 2);
    check("b2_err_cnt", cnt_at_done, 2);

    run_window(0, -1, -1, 1'b1, 0);
    check("b4_latency", lat, 39);
    check("b4_err_cnt", cnt_at_done, 0);
    check("b4_err_pulses", err_pulses, 0);

    run_window(2, -1, -1, 1'b0, 0);
    check("b3_err_cnt", cnt_at_done, 16);
    check("b3_err_pulses", err_pulses, 16);
    check("b3_hold", err_cnt, 16);

    // Reset after 8 measured beats, the 8th one mismatching.
    bn = 0;
    start = 1'b1;
    drive_beat(1'b1, 1'b0);
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      w = bn - DELAY;
      drive_beat(1'b1, w == 8);
    end
    @(posedge clk); #1;
    check("b5_busy_pre", busy, 1);
    check("b5_err_pre", err, 1);
    check("b5_cnt_hold", err_cnt, 16);
    valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("b5_rst_busy", busy, 0);
    check("b5_rst_err", err, 0);
    check("b5_rst_done", done, 0);
    check("b5_rst_cnt", err_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle_busy = 0;
    bn = 0;
    for (int c = 0; c < 4; c++) begin
      drive_beat(1'b1, 1'b0);
      @(posedge clk); #1;
      if (busy || done) idle_busy++;
    end
    check("b5_needs_start", idle_busy, 0);
    run_window(1, 7, -1, 1'b0, 10);
    check("b5_latency", lat, 20);
    check("b5_busy_cycles", busy_cyc, 19);
    check("b5_done_pulses", done_pulses, 1);
    check("b5_err_pulses", err_pulses, 1);
    check("b5_err_cnt", cnt_at_done, 1);
`else
    // Windows: beats 1..16, 17..32, 33..48; errors at beats 1, 17 and 18.
    for (int i = 0; i < 3; i++) begin
      d_at[i]  = -1;
      d_cnt[i] = -1;
    end
    nd = 0;
    bn = 0;
    start = 1'b1;
    drive_beat(1'b1, 1'b0);
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done && (nd < 3)) begin
        d_at[nd]  = c;
        d_cnt[nd] = int'(err_cnt);
        nd++;
      end
      w = bn - DELAY;
      drive_beat(1'b1, (w == 1) || (w == 17) || (w == 18));
    end
    check("b6_windows", nd, 3);
    check("b6_done0_at", d_at[0], 20);
    check("b6_done1_at", d_at[1], 36);
    check("b6_done2_at", d_at[2], 52);
    check("b6_cnt0", d_cnt[0], 1);
    check("b6_cnt1", d_cnt[1], 2);
    check("b6_cnt2", d_cnt[2], 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
